// File: rtl/aline_fire_scheduler.sv
// A-line transmit scheduler: requests a delay reload, then fires a 32-bit pulse pattern on each
// enabled channel at its own delay, for a programmable number of A-lines per frame.
module aline_fire_scheduler #(
   parameter int unsigned GAP_CYCLES   = 16,
   parameter int unsigned LOAD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        intaking_configs,
   input  logic        updating_delays,
   input  logic [7:0]  channel_select,
   input  logic [4:0]  aline_select,
   input  logic [31:0] pulse_shape,
   input  logic [15:0] ch0delay,
   input  logic [15:0] ch1delay,
   input  logic [15:0] ch2delay,
   input  logic [15:0] ch3delay,
   input  logic [15:0] ch4delay,
   input  logic [15:0] ch5delay,
   input  logic [15:0] ch6delay,
   input  logic [15:0] ch7delay,
   output logic        rd_en,
   output logic [3:0]  which_aline,
   output logic [7:0]  pulse_out,
   output logic        busy,
   output logic        aline_done,
   output logic        frame_done,
   output logic        load_err
);

   localparam int unsigned WaitW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT + 1);
   localparam int unsigned GapW  = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      StIdle, StLoadReq, StLoadWait, StArm, StFire, StGap, StDone
   } state_e;

   state_e             state_q, state_d;
   logic [7:0]         sel_q, sel_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [3:0]         which_q, which_d;
   logic               seen_q, seen_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic [GapW-1:0]    gap_q, gap_d;
   logic [7:0][15:0]   dly_q, dly_d;
   logic [31:0]        shape_q, shape_d;
   logic [16:0]        end_q, end_d;
   logic [16:0]        t_q, t_d;
   logic               rd_en_q, rd_en_d;
   logic [7:0]         pulse_q, pulse_d;
   logic               busy_q, busy_d;
   logic               aline_done_q, aline_done_d;
   logic               frame_done_q, frame_done_d;
   logic               load_err_q, load_err_d;

   logic [7:0][15:0]   dly_in;
   logic [15:0]        max_dly;
   logic [4:0]         cnt_sel;

   assign dly_in = {ch7delay, ch6delay, ch5delay, ch4delay,
                    ch3delay, ch2delay, ch1delay, ch0delay};

   // Channel outputs for FIRE time t; each channel walks its pattern MSB first from its delay.
   function automatic logic [7:0] fire_bits(input logic [16:0]      t,
                                            input logic [31:0]      shape,
                                            input logic [7:0][15:0] dly,
                                            input logic [7:0]       sel);
      logic [16:0] off;
      fire_bits = '0;
      for (int i = 0; i < 8; i++) begin
         off = t - {1'b0, dly[i]};
         if (sel[i] && (t >= {1'b0, dly[i]}) && (off < 17'd32)) begin
            fire_bits[i] = shape[5'd31 - off[4:0]];
         end
      end
   endfunction

   always_comb begin
      max_dly = '0;
      for (int i = 0; i < 8; i++) begin
         if (sel_q[i] && (dly_in[i] > max_dly)) max_dly = dly_in[i];
      end
   end

   assign cnt_sel = (aline_select > 5'd16) ? 5'd16 : aline_select;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      which_d      = which_q;
      seen_d       = seen_q;
      wait_d       = wait_q;
      gap_d        = gap_q;
      dly_d        = dly_q;
      shape_d      = shape_q;
      end_d        = end_q;
      t_d          = t_q;
      busy_d       = busy_q;
      rd_en_d      = 1'b0;
      pulse_d      = '0;
      aline_done_d = 1'b0;
      frame_done_d = 1'b0;
      load_err_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start && !intaking_configs) begin
               sel_d   = channel_select;
               cnt_d   = cnt_sel;
               which_d = '0;
               busy_d  = 1'b1;
               if ((cnt_sel == 5'd0) || (channel_select == 8'd0)) begin
                  state_d = StDone;
               end else begin
                  state_d = StLoadReq;
                  rd_en_d = 1'b1;
               end
            end
         end
         StLoadReq: begin
            state_d = StLoadWait;
            seen_d  = 1'b0;
            wait_d  = '0;
         end
         StLoadWait: begin
            if (updating_delays) seen_d = 1'b1;
            if (!updating_delays && seen_q) begin
               state_d = StArm;
            end else if (32'(wait_q) + 32'd1 >= LOAD_TIMEOUT) begin
               load_err_d = 1'b1;
               busy_d     = 1'b0;
               state_d    = StIdle;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StArm: begin
            dly_d   = dly_in;
            shape_d = pulse_shape;
            end_d   = {1'b0, max_dly} + 17'd32;
            t_d     = '0;
            // pulse_out is registered, so the t=0 value is prepared here from the live inputs.
            pulse_d = fire_bits(17'd0, pulse_shape, dly_in, sel_q);
            state_d = StFire;
         end
         StFire: begin
            t_d = t_q + 17'd1;
            if (t_q == end_q - 17'd1) begin
               aline_done_d = 1'b1;
               if ({1'b0, which_q} + 5'd1 == cnt_q) begin
                  state_d = StDone;
               end else begin
                  which_d = which_q + 4'd1;
                  if (GAP_CYCLES == 0) begin
                     state_d = StLoadReq;
                     rd_en_d = 1'b1;
                  end else begin
                     state_d = StGap;
                     gap_d   = '0;
                  end
               end
            end else begin
               pulse_d = fire_bits(t_q + 17'd1, shape_q, dly_q, sel_q);
            end
         end
         StGap: begin
            if (32'(gap_q) + 32'd1 >= GAP_CYCLES) begin
               state_d = StLoadReq;
               rd_en_d = 1'b1;
            end else begin
               gap_d = gap_q + GapW'(1);
            end
         end
         StDone: begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d      = StIdle;
         busy_d       = 1'b0;
         rd_en_d      = 1'b0;
         pulse_d      = '0;
         aline_done_d = 1'b0;
         frame_done_d = 1'b0;
         load_err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         sel_q        <= '0;
         cnt_q        <= '0;
         which_q      <= '0;
         seen_q       <= 1'b0;
         wait_q       <= '0;
         gap_q        <= '0;
         dly_q        <= '0;
         shape_q      <= '0;
         end_q        <= '0;
         t_q          <= '0;
         rd_en_q      <= 1'b0;
         pulse_q      <= '0;
         busy_q       <= 1'b0;
         aline_done_q <= 1'b0;
         frame_done_q <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         which_q      <= which_d;
         seen_q       <= seen_d;
         wait_q       <= wait_d;
         gap_q        <= gap_d;
         dly_q        <= dly_d;
         shape_q      <= shape_d;
         end_q        <= end_d;
         t_q          <= t_d;
         rd_en_q      <= rd_en_d;
         pulse_q      <= pulse_d;
         busy_q       <= busy_d;
         aline_done_q <= aline_done_d;
         frame_done_q <= frame_done_d;
         load_err_q   <= load_err_d;
      end
   end

   assign rd_en       = rd_en_q;
   assign which_aline = which_q;
   assign pulse_out   = pulse_q;
   assign busy        = busy_q;
   assign aline_done  = aline_done_q;
   assign frame_done  = frame_done_q;
   assign load_err    = load_err_q;

endmodule

// File: tb/tb_aline_fire_scheduler.sv
// Bench for aline_fire_scheduler: frame-level vector table, hand-written corner sequences and
// randomized frames compared cycle by cycle against a timeline model.
module tb_aline_fire_scheduler;

   localparam int MAXO = 1024;

   typedef struct packed {
      logic       rd;
      logic [3:0] which;
      logic [7:0] pulse;
      logic       ad;
      logic       fd;
      logic       busy;
      logic       le;
   } obs_t;

   typedef struct {
      logic [4:0]  alsel;
      logic [7:0]  sel;
      int          dbase;
      int          dstep;
      logic [31:0] shape;
      int          rd_cnt;
      int          ad_cnt;
      int          fd_obs;
      int          first_rd;
      int          span;
      int          ones;
      logic [7:0]  or_mask;
      int          last_which;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        intaking_configs = 1'b0;
   logic        updating_delays = 1'b0;
   logic [7:0]  channel_select = '0;
   logic [4:0]  aline_select = '0;
   logic [31:0] pulse_shape = '0;
   logic [15:0] ch0delay = '0, ch1delay = '0, ch2delay = '0, ch3delay = '0;
   logic [15:0] ch4delay = '0, ch5delay = '0, ch6delay = '0, ch7delay = '0;
   logic        rd_en, busy, aline_done, frame_done, load_err;
   logic [3:0]  which_aline;
   logic [7:0]  pulse_out;

   int   checks = 0;
   int   failures = 0;
   int   dly_cfg[8];
   obs_t rec[MAXO];
   obs_t expd[MAXO];
   vec_t tbl[6];

   aline_fire_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .intaking_configs(intaking_configs), .updating_delays(updating_delays),
      .channel_select(channel_select), .aline_select(aline_select), .pulse_shape(pulse_shape),
      .ch0delay(ch0delay), .ch1delay(ch1delay), .ch2delay(ch2delay), .ch3delay(ch3delay),
      .ch4delay(ch4delay), .ch5delay(ch5delay), .ch6delay(ch6delay), .ch7delay(ch7delay),
      .rd_en(rd_en), .which_aline(which_aline), .pulse_out(pulse_out), .busy(busy),
      .aline_done(aline_done), .frame_done(frame_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      updating_delays = 1'b0;
      intaking_configs = 1'b0;
      tick();
      tick();
      check_int("reset_state",
                int'({rd_en, which_aline, pulse_out, aline_done, frame_done, busy, load_err}), 0);
   endtask

   task automatic set_cfg(input logic [7:0] sel, input logic [4:0] alsel,
                          input logic [31:0] shape);
      channel_select = sel;
      aline_select = alsel;
      pulse_shape = shape;
      ch0delay = 16'(dly_cfg[0]); ch1delay = 16'(dly_cfg[1]);
      ch2delay = 16'(dly_cfg[2]); ch3delay = 16'(dly_cfg[3]);
      ch4delay = 16'(dly_cfg[4]); ch5delay = 16'(dly_cfg[5]);
      ch6delay = 16'(dly_cfg[6]); ch7delay = 16'(dly_cfg[7]);
   endtask

   // Releases reset together with start, then records outputs each cycle. updating_delays is
   // held high for u cycles after a p-cycle pause following every rd_en. cut_at >= 0 applies
   // abort (or reset if cut_rst) for one edge after that observation.
   task automatic run_frame(input int p, input int u, input int cut_at, input bit cut_rst,
                            input bit scramble, output int n);
      int k, last_rd;
      bit stop;
      last_rd = -1000000;
      rst = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
         rec[k] = '{rd: rd_en, which: which_aline, pulse: pulse_out, ad: aline_done,
                    fd: frame_done, busy: busy, le: load_err};
         if (rd_en) last_rd = k;
         updating_delays = (k - last_rd >= 1 + p) && (k - last_rd <= p + u);
         if (scramble) begin
            channel_select = 8'($urandom);
            aline_select = 5'($urandom);
         end
         abort = (k == cut_at) && !cut_rst;
         rst = !((k == cut_at) && cut_rst);
         if (frame_done || load_err || (cut_at >= 0 && k == cut_at + 40)) begin
            n = k + 1;
            stop = 1'b1;
         end else if (k == MAXO - 1) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got no frame end after %0d cycles expected end", MAXO);
            n = MAXO;
            stop = 1'b1;
         end else begin
            tick();
            k++;
         end
      end
      abort = 1'b0;
      rst = 1'b1;
      updating_delays = 1'b0;
   endtask

   // Timeline model: each A-line is rd_en, p+u+2 load/arm cycles, FIRE for max(delay)+32
   // cycles, then either a 16-cycle gap or DONE followed by frame_done.
   task automatic build_expected(input logic [7:0] sel, input int alsel, input logic [31:0] shape,
                                 input int p, input int u, output int n_exp);
      int cnt, r, fs, endt, mx;
      for (int k = 0; k < MAXO; k++) expd[k] = '0;
      cnt = (alsel > 16) ? 16 : alsel;
      if (cnt == 0 || sel == 8'd0) begin
         expd[0].busy = 1'b1;
         expd[1].fd = 1'b1;
         n_exp = 2;
         return;
      end
      mx = 0;
      for (int i = 0; i < 8; i++) if (sel[i] && dly_cfg[i] > mx) mx = dly_cfg[i];
      endt = mx + 32;
      r = 0;
      n_exp = 0;
      for (int a = 0; a < cnt; a++) begin
         fs = r + p + u + 3;
         for (int k = r; k < fs + endt; k++) begin
            expd[k].busy = 1'b1;
            expd[k].which = 4'(a);
         end
         expd[r].rd = 1'b1;
         for (int t = 0; t < endt; t++) begin
            for (int i = 0; i < 8; i++) begin
               if (sel[i] && t >= dly_cfg[i] && t < dly_cfg[i] + 32)
                  expd[fs + t].pulse[i] = shape[31 - (t - dly_cfg[i])];
            end
         end
         expd[fs + endt].ad = 1'b1;
         if (a == cnt - 1) begin
            expd[fs + endt].busy = 1'b1;
            expd[fs + endt].which = 4'(a);
            expd[fs + endt + 1].fd = 1'b1;
            expd[fs + endt + 1].which = 4'(a);
            n_exp = fs + endt + 2;
         end else begin
            for (int k = fs + endt; k < fs + endt + 16; k++) begin
               expd[k].busy = 1'b1;
               expd[k].which = 4'(a + 1);
            end
            r = fs + endt + 16;
         end
      end
   endtask

   initial begin
      int n, n_exp, mm, quiet;
      int rd_c, ad_c, fd_o, first_p, first_r, first_a, ones, lw, seq_err;
      logic [7:0] om, rsel;
      logic [31:0] rshape;
      int ralsel, rp, ru;
      bit scr;

      tbl[0] = '{5'd2,  8'h01, 3, 0, 32'h8000_0001, 2,  2,  97,  8,  32, 4,   8'h01, 1};
      tbl[1] = '{5'd1,  8'hFF, 0, 4, 32'hFFFF_FFFF, 1,  1,  66,  5,  60, 256, 8'hFF, 0};
      tbl[2] = '{5'd0,  8'hFF, 0, 0, 32'hFFFF_FFFF, 0,  0,  1,   -1, -1, 0,   8'h00, 0};
      tbl[3] = '{5'd3,  8'h00, 0, 0, 32'hFFFF_FFFF, 0,  0,  1,   -1, -1, 0,   8'h00, 0};
      tbl[4] = '{5'd20, 8'h01, 0, 0, 32'h0000_0001, 16, 16, 833, 36, 1,  16,  8'h01, 15};
      tbl[5] = '{5'd1,  8'h05, 0, 0, 32'hFFFF_FFFF, 1,  1,  38,  5,  32, 64,  8'h05, 0};

      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int i = 0; i < 8; i++) dly_cfg[i] = tbl[v].dbase + i * tbl[v].dstep;
         set_cfg(tbl[v].sel, tbl[v].alsel, tbl[v].shape);
         run_frame(0, 2, -1, 1'b0, 1'b0, n);
         rd_c = 0; ad_c = 0; fd_o = -1; first_p = -1; first_r = -1; first_a = -1;
         ones = 0; om = '0; lw = -1; seq_err = 0;
         for (int k = 0; k < n; k++) begin
            if (rec[k].rd) begin
               if (int'(rec[k].which) != rd_c) seq_err++;
               if (first_r < 0) first_r = k;
               rd_c++;
            end
            if (rec[k].ad) begin
               if (first_a < 0) first_a = k;
               ad_c++;
            end
            if (rec[k].fd && fd_o < 0) begin
               fd_o = k;
               lw = int'(rec[k].which);
            end
            if (rec[k].pulse != 8'd0 && first_p < 0) first_p = k;
            ones += $countones(rec[k].pulse);
            om |= rec[k].pulse;
         end
         check_int($sformatf("v%0d_rd_count", v), rd_c, tbl[v].rd_cnt);
         check_int($sformatf("v%0d_aline_done_count", v), ad_c, tbl[v].ad_cnt);
         check_int($sformatf("v%0d_frame_done_cycle", v), fd_o, tbl[v].fd_obs);
         check_int($sformatf("v%0d_pulse_ones", v), ones, tbl[v].ones);
         check_int($sformatf("v%0d_pulse_mask", v), int'(om), int'(tbl[v].or_mask));
         check_int($sformatf("v%0d_last_which", v), lw, tbl[v].last_which);
         check_int($sformatf("v%0d_which_seq_errs", v), seq_err, 0);
         if (tbl[v].first_rd >= 0)
            check_int($sformatf("v%0d_first_pulse_after_rd", v), first_p - first_r, tbl[v].first_rd);
         if (tbl[v].span >= 0)
            check_int($sformatf("v%0d_fire_tail_span", v), first_a - first_p, tbl[v].span);
      end

      // start is ignored while a config load is in progress
      do_reset();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) dly_cfg[i] = 0;
      set_cfg(8'h01, 5'd1, 32'hFFFF_FFFF);
      intaking_configs = 1'b1;
      start = 1'b1;
      repeat (5) tick();
      check_int("intake_blocks_start", int'({busy, rd_en}), 0);
      intaking_configs = 1'b0;
      tick();
      start = 1'b0;
      check_int("intake_release_start", int'({busy, rd_en}), 3);

      // no delay-reload handshake: error after the wait budget
      do_reset();
      set_cfg(8'h01, 5'd1, 32'hFFFF_FFFF);
      run_frame(100000, 1, -1, 1'b0, 1'b0, n);
      check_int("timeout_cycle", n - 1, 256);
      check_int("timeout_load_err", int'(rec[n - 1].le), 1);
      check_int("timeout_busy", int'(rec[n - 1].busy), 0);
      quiet = 0;
      for (int k = 0; k < n; k++) quiet += $countones(rec[k].pulse) + int'(rec[k].ad);
      check_int("timeout_no_fire", quiet, 0);

      // abort, then reset, at FIRE t=10 (observation 15); each followed by a clean frame
      for (int c = 0; c < 2; c++) begin
         do_reset();
         set_cfg(8'h01, 5'd1, 32'hFFFF_FFFF);
         run_frame(0, 2, 15, c == 1, 1'b0, n);
         check_int($sformatf("cut%0d_firing_before", c), int'(rec[15].pulse), 1);
         check_int($sformatf("cut%0d_outputs_after", c), int'(rec[16]), 0);
         quiet = 0;
         for (int k = 16; k < n; k++)
            quiet += int'(rec[k].ad) + int'(rec[k].fd) + int'(rec[k].rd) + int'(rec[k].busy)
                     + $countones(rec[k].pulse);
         check_int($sformatf("cut%0d_quiet", c), quiet, 0);
         run_frame(0, 2, -1, 1'b0, 1'b0, n);
         check_int($sformatf("cut%0d_next_frame_len", c), n, 39);
      end

      // randomized frames against the timeline model
      for (int f = 0; f < 25; f++) begin
         rsel = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         ralsel = $urandom_range(0, 5);
         rshape = $urandom;
         rp = $urandom_range(0, 5);
         ru = $urandom_range(1, 4);
         scr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            dly_cfg[0] = $urandom_range(0, 40);
            for (int i = 1; i < 8; i++) dly_cfg[i] = dly_cfg[0];
         end else begin
            for (int i = 0; i < 8; i++) dly_cfg[i] = $urandom_range(0, 40);
         end
         do_reset();
         set_cfg(rsel, 5'(ralsel), rshape);
         build_expected(rsel, ralsel, rshape, rp, ru, n_exp);
         run_frame(rp, ru, -1, 1'b0, scr, n);
         check_int($sformatf("rand%0d_frame_len", f), n, n_exp);
         checks++;
         mm = -1;
         for (int k = 0; k < ((n < n_exp) ? n : n_exp); k++) begin
            if (rec[k] !== expd[k]) begin
               mm = k;
               break;
            end
         end
         if (mm >= 0) begin
            failures++;
            $display("FAIL rand%0d_trace cycle=%0d got rd=%0b which=%0d pulse=%h ad=%0b fd=%0b busy=%0b le=%0b expected rd=%0b which=%0d pulse=%h ad=%0b fd=%0b busy=%0b le=%0b",
                     f, mm, rec[mm].rd, rec[mm].which, rec[mm].pulse, rec[mm].ad, rec[mm].fd,
                     rec[mm].busy, rec[mm].le, expd[mm].rd, expd[mm].which, expd[mm].pulse,
                     expd[mm].ad, expd[mm].fd, expd[mm].busy, expd[mm].le);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aline_fire_scheduler.md
ALINE_FIRE_SCHEDULER -- requirements
Module: aline_fire_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle guard cycles between consecutive A-lines.
REQ-002 Parameter LOAD_TIMEOUT, default 255: maximum cycles spent waiting for a delay reload before the scheduler flags an error.
REQ-003 clk  in  1  single system clock; all logic is on posedge clk.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 start  in  1  frame start request, level-sampled in IDLE.
REQ-006 abort  in  1  synchronous abort; highest priority after reset.
REQ-007 intaking_configs  in  1  config load in progress; blocks start.
REQ-008 updating_delays  in  1  delay reload in progress.
REQ-009 channel_select  in  8  per-channel enable.
REQ-010 aline_select  in  5  number of A-lines per frame.
REQ-011 pulse_shape  in  32  transmit bit pattern, emitted MSB first.
REQ-012 ch0delay..ch7delay  in  16 each  per-channel fire delay, in cycles.
REQ-013 rd_en  out  1  one-cycle delay-reload request.
REQ-014 which_aline  out  4  index of the current A-line.
REQ-015 pulse_out  out  8  per-channel transmit outputs.
REQ-016 busy, aline_done, frame_done, load_err  out  1 each  status outputs; aline_done, frame_done and load_err are one-cycle pulses.

Function
REQ-017 The scheduler SHALL implement exactly these states: IDLE, LOAD_REQ, LOAD_WAIT, ARM, FIRE, GAP, DONE.
REQ-018 In IDLE, when start=1 and intaking_configs=0, the scheduler SHALL:
- latch channel_select into sel_q;
- latch the A-line count as min(aline_select, 16) into cnt_q;
- set which_aline=0 and busy=1;
- go to LOAD_REQ, or go to DONE if cnt_q=0 or sel_q=0.
REQ-019 In IDLE, start SHALL be ignored while intaking_configs=1.
REQ-020 LOAD_REQ SHALL drive rd_en=1 for exactly one cycle, with which_aline stable, then go to LOAD_WAIT.
REQ-021 LOAD_WAIT SHALL:
- set a seen flag when updating_delays=1;
- go to ARM on the first cycle where updating_delays=0 with seen set;
- otherwise increment a wait counter.
REQ-022 When the wait counter reaches LOAD_TIMEOUT, the scheduler SHALL pulse load_err, clear busy, and go to IDLE.
REQ-023 ARM SHALL, in one cycle:
- latch ch0delay..ch7delay and pulse_shape;
- compute end_t = (max latched delay among enabled channels) + 32, 17-bit, no overflow;
- clear the 17-bit timer t.
REQ-024 In FIRE, t SHALL increment every cycle.
REQ-025 In FIRE, pulse_out[i] SHALL equal pulse_shape_q[31-(t-delay_i)] when sel_q[i]=1 and delay_i <= t < delay_i+32, and 0 otherwise; pulse_out is registered.
REQ-026 FIRE SHALL exit when t == end_t-1. On exit the scheduler SHALL pulse aline_done and force pulse_out=0.
REQ-027 After FIRE, if which_aline+1 == cnt_q the scheduler SHALL go to DONE; otherwise it SHALL increment which_aline and go to GAP.
REQ-028 GAP SHALL hold for GAP_CYCLES cycles, then go to LOAD_REQ; if GAP_CYCLES=0 it SHALL go directly to LOAD_REQ.
REQ-029 DONE SHALL pulse frame_done for one cycle, clear busy, and go to IDLE. which_aline SHALL hold its last value until the next start.
REQ-030 Equal delays on several channels SHALL fire those channels in the same cycles; delay=0 SHALL fire on the first FIRE cycle.
REQ-031 Disabled channels SHALL never assert pulse_out.
REQ-032 abort=1 in any state SHALL, next cycle:
- go to IDLE;
- drive pulse_out=0, busy=0, rd_en=0;
- emit no done pulse.
REQ-033 Input changes to channel_select, pulse_shape or the delays outside IDLE/ARM latch points SHALL NOT affect the A-line in progress.

Reset
REQ-034 While rst=0 at posedge clk:
- state=IDLE;
- rd_en=0, which_aline=0, pulse_out=0;
- busy=0, aline_done=0, frame_done=0, load_err=0;
- timers, counters and latched registers cleared.
REQ-035 Reset asserted mid-FIRE SHALL zero pulse_out on the same edge, and no done pulse SHALL follow.
REQ-036 After rst returns high the scheduler SHALL accept start on the first cycle.

Verification
REQ-037 aline_select=2, channel_select=8'h01, ch0delay=3, pulse_shape=32'h8000_0001, updating_delays high for 2 cycles after each rd_en -> per A-line:
- pulse_out[0] high at FIRE t=3 and t=34 only;
- two rd_en pulses, which_aline 0 then 1;
- two aline_done pulses, one frame_done.
REQ-038 channel_select=8'hFF, delays ch_i=i*4, pulse_shape=32'hFFFF_FFFF -> channel i high for 32 cycles starting at t=4i; FIRE lasts 60 cycles.
REQ-039 updating_delays never asserted after rd_en -> load_err pulses after 255 wait cycles; busy=0; no pulse_out activity.
REQ-040 aline_select=0, or channel_select=0 -> frame_done one cycle after DONE is entered; no rd_en.
REQ-041 aline_select=5'd20 -> exactly 16 A-lines; which_aline sequences 0..15.
REQ-042 abort at FIRE t=10, and separately rst=0 at FIRE t=10 -> pulse_out=0 next cycle, state IDLE, no aline_done or frame_done pulse.
